// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with writeback select, one-shot register-file write,
// a forwarding tap that stays live while the entry is held, and a retired counter.
module writeback_stage #(
  parameter int W  = 16,
  parameter int N  = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic [2:0]    wb_signals,
  input  logic [W-1:0]  alu_result,
  input  logic [W-1:0]  mem_data,
  input  logic [W-1:0]  imm,
  input  logic [W-1:0]  in_port,
  input  logic [N-1:0]  dst_addr,
  input  logic          stall,
  input  logic          flush,
  output logic          regWrite,
  output logic [W-1:0]  WD,
  output logic [N-1:0]  WA,
  output logic          fwd_en,
  output logic [N-1:0]  fwd_addr,
  output logic [W-1:0]  fwd_data,
  output logic [CW-1:0] retired
);

  typedef enum logic [1:0] {
    SEL_ALU = 2'b00,
    SEL_MEM = 2'b01,
    SEL_IMM = 2'b10,
    SEL_INP = 2'b11
  } wb_sel_e;

  logic          valid_q;
  logic          presented_q;
  logic          rw_q;
  wb_sel_e       sel_q;
  logic [W-1:0]  alu_q;
  logic [W-1:0]  mem_q;
  logic [W-1:0]  imm_q;
  logic [W-1:0]  inp_q;
  logic [N-1:0]  dst_q;
  logic [CW-1:0] retired_q;
  logic [CW-1:0] retired_d;
  logic [W-1:0]  wd_d;

  // Only a real load of a valid instruction counts; flush and stall edges never do.
  always_comb begin
    retired_d = retired_q;
    if (!flush && !stall && mem_valid) begin
      retired_d = retired_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      presented_q <= 1'b0;
      rw_q        <= 1'b0;
      sel_q       <= SEL_ALU;
      alu_q       <= '0;
      mem_q       <= '0;
      imm_q       <= '0;
      inp_q       <= '0;
      dst_q       <= '0;
      retired_q   <= '0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      presented_q <= 1'b1;
    end else if (stall) begin
      // Held entry must not issue a second register-file write.
      presented_q <= 1'b0;
    end else begin
      valid_q     <= mem_valid;
      presented_q <= 1'b1;
      rw_q        <= wb_signals[2];
      sel_q       <= wb_sel_e'(wb_signals[1:0]);
      alu_q       <= alu_result;
      mem_q       <= mem_data;
      imm_q       <= imm;
      inp_q       <= in_port;
      dst_q       <= dst_addr;
      retired_q   <= retired_d;
    end
  end

  // NOTE: a default assignment ahead of the case keeps this block free of latches.
  always_comb begin
    wd_d = alu_q;
    unique case (sel_q)
      SEL_ALU: wd_d = alu_q;
      SEL_MEM: wd_d = mem_q;
      SEL_IMM: wd_d = imm_q;
      SEL_INP: wd_d = inp_q;
    endcase
  end

  assign WD       = wd_d;
  assign WA       = dst_q;
  assign regWrite = valid_q & rw_q & presented_q;
  assign fwd_en   = valid_q & rw_q;
  assign fwd_addr = dst_q;
  assign fwd_data = wd_d;
  assign retired  = retired_q;

endmodule
